// File: rtl/nic_pkg.sv
// Shared types and constants for the Wishbone one-master-to-N-slave interconnect.
package nic_pkg;

  typedef enum logic [1:0] {
    NIC_IDLE,
    NIC_ACTIVE,
    NIC_RESP
  } nic_state_t;

  localparam logic [31:0]  NIC_ERR_DATA        = 32'hDEAD_BEEF;
  localparam int unsigned  NIC_ERR_COUNT_WIDTH = 16;

endpackage

// File: rtl/nic_watchdog.sv
// Wait-cycle counter for one outstanding transaction; flags the last allowed cycle.
module nic_watchdog #(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] limit,
  output logic                   expired_c
);

  logic [COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  // A zero limit disables expiry entirely.
  assign expired_c = enable && (limit != '0) && (count_q == limit - COUNT_WIDTH'(1));

endmodule

// File: rtl/wb_nic.sv
// Registered Wishbone interconnect: one-hot slave select, response mux, timeout and
// unmapped-slave error responses with saturating error status.
module wb_nic
  import nic_pkg::*;
#(
  parameter int unsigned                     ADDR_SEL_WIDTH = 4,
  parameter int unsigned                     DATA_WIDTH     = 32,
  parameter logic [(2**ADDR_SEL_WIDTH)-1:0]  SLAVE_MASK     = '1,
  parameter int unsigned                     TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                     ERR_DATA       = NIC_ERR_DATA
) (
  input  logic                                         i_clk,
  input  logic                                         i_reset,
  input  logic                                         i_wb_cyc,
  input  logic                                         i_wb_stb,
  input  logic [ADDR_SEL_WIDTH-1:0]                    i_addr_sel,
  input  logic [(2**ADDR_SEL_WIDTH)*DATA_WIDTH-1:0]    i_rdata,
  input  logic [(2**ADDR_SEL_WIDTH)-1:0]               i_ack,
  output logic [(2**ADDR_SEL_WIDTH)-1:0]               o_slave_sel,
  output logic [DATA_WIDTH-1:0]                        o_rdata,
  output logic                                         o_ack,
  output logic                                         o_err,
  output logic                                         o_busy,
  output logic [NIC_ERR_COUNT_WIDTH-1:0]               o_err_count,
  output logic [ADDR_SEL_WIDTH-1:0]                    o_err_sel
);

  localparam int unsigned SLAVE_COUNT = 2**ADDR_SEL_WIDTH;
  localparam int unsigned WD_WIDTH    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  nic_state_t                     state_q, state_d;
  logic [ADDR_SEL_WIDTH-1:0]      sel_q, sel_d;
  logic [SLAVE_COUNT-1:0]         slave_sel_d;
  logic [DATA_WIDTH-1:0]          rdata_d;
  logic                           ack_d, err_d, busy_d;
  logic [NIC_ERR_COUNT_WIDTH-1:0] err_count_d;
  logic [ADDR_SEL_WIDTH-1:0]      err_sel_d;
  logic                           expired_c;
  logic [DATA_WIDTH-1:0]          slave_rdata [SLAVE_COUNT];

  for (genvar i = 0; i < SLAVE_COUNT; i++) begin : g_rdata
    assign slave_rdata[i] = i_rdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  nic_watchdog #(
    .COUNT_WIDTH (WD_WIDTH)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .clear     (state_q != NIC_ACTIVE),
    .enable    (state_q == NIC_ACTIVE),
    .limit     (WD_WIDTH'(TIMEOUT_CYCLES)),
    .expired_c (expired_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= NIC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next registered outputs; cyc drop beats ack, ack beats timeout.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    slave_sel_d = o_slave_sel;
    rdata_d     = o_rdata;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    err_count_d = o_err_count;
    err_sel_d   = o_err_sel;

    case (state_q)
      NIC_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          sel_d = i_addr_sel;
          if (!SLAVE_MASK[i_addr_sel]) begin
            state_d = NIC_RESP;
            err_d   = 1'b1;
          end else begin
            state_d     = NIC_ACTIVE;
            slave_sel_d = SLAVE_COUNT'(1) << i_addr_sel;
          end
        end
      end
      NIC_ACTIVE: begin
        if (!i_wb_cyc) begin
          state_d     = NIC_IDLE;
          slave_sel_d = '0;
        end else if (i_ack[sel_q]) begin
          state_d     = NIC_RESP;
          slave_sel_d = '0;
          rdata_d     = slave_rdata[sel_q];
          ack_d       = 1'b1;
        end else if (expired_c) begin
          state_d     = NIC_RESP;
          slave_sel_d = '0;
          err_d       = 1'b1;
        end
      end
      NIC_RESP: begin
        state_d = NIC_IDLE;
      end
      default: begin
        state_d = NIC_IDLE;
      end
    endcase

    if (err_d) begin
      rdata_d   = DATA_WIDTH'(ERR_DATA);
      err_sel_d = sel_d;
      if (o_err_count != '1) begin
        err_count_d = o_err_count + NIC_ERR_COUNT_WIDTH'(1);
      end
    end

    busy_d = (state_d != NIC_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sel_q       <= '0;
      o_slave_sel <= '0;
      o_rdata     <= '0;
      o_ack       <= 1'b0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
      o_err_count <= '0;
      o_err_sel   <= '0;
    end else begin
      sel_q       <= sel_d;
      o_slave_sel <= slave_sel_d;
      o_rdata     <= rdata_d;
      o_ack       <= ack_d;
      o_err       <= err_d;
      o_busy      <= busy_d;
      o_err_count <= err_count_d;
      o_err_sel   <= err_sel_d;
    end
  end

endmodule

// File: tb/tb_wb_nic.sv
// Self-checking bench for wb_nic: directed corner cases, randomized traffic and
// error-counter saturation, all checked against a transaction-level model.
module tb_wb_nic;

  localparam int unsigned ASW  = 4;
  localparam int unsigned NS   = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned TMO  = 8;
  localparam logic [15:0] MASK = 16'h0507;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_wb_cyc = 1'b0;
  logic          i_wb_stb = 1'b0;
  logic [3:0]    i_addr_sel = '0;
  logic [511:0]  i_rdata = '0;
  logic [15:0]   i_ack = '0;
  logic [15:0]   o_slave_sel;
  logic [31:0]   o_rdata;
  logic          o_ack, o_err, o_busy;
  logic [15:0]   o_err_count;
  logic [3:0]    o_err_sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_nic #(
    .ADDR_SEL_WIDTH (ASW),
    .DATA_WIDTH     (DW),
    .SLAVE_MASK     (MASK),
    .TIMEOUT_CYCLES (TMO),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_wb_cyc    (i_wb_cyc),
    .i_wb_stb    (i_wb_stb),
    .i_addr_sel  (i_addr_sel),
    .i_rdata     (i_rdata),
    .i_ack       (i_ack),
    .o_slave_sel (o_slave_sel),
    .o_rdata     (o_rdata),
    .o_ack       (o_ack),
    .o_err       (o_err),
    .o_busy      (o_busy),
    .o_err_count (o_err_count),
    .o_err_sel   (o_err_sel)
  );

  // Transaction-level model: an outstanding request, its age, and a pending response.
  bit          m_wait = 0;
  bit          m_resp = 0;
  int          m_age  = 0;
  logic [3:0]  m_wsel = '0;
  logic [15:0] m_sel_oh = '0;
  logic [31:0] m_rdata = '0;
  bit          m_ack = 0, m_err = 0, m_busy = 0;
  int          m_cnt = 0;
  logic [3:0]  m_esel = '0;

  task automatic error_resp(input logic [3:0] s);
    m_resp   = 1;
    m_err    = 1;
    m_ack    = 0;
    m_busy   = 1;
    m_sel_oh = '0;
    m_rdata  = 32'hDEAD_BEEF;
    if (m_cnt < 65535) m_cnt++;
    m_esel   = s;
  endtask

  task automatic model_step();
    if (i_reset) begin
      m_wait = 0; m_resp = 0; m_age = 0; m_sel_oh = '0; m_rdata = '0;
      m_ack = 0; m_err = 0; m_busy = 0; m_cnt = 0; m_esel = '0;
      return;
    end
    if (m_resp) begin
      m_resp = 0; m_ack = 0; m_err = 0; m_busy = 0;
    end else if (!m_wait) begin
      if (i_wb_cyc && i_wb_stb) begin
        if (MASK[i_addr_sel]) begin
          m_wait = 1; m_wsel = i_addr_sel; m_age = 0;
          m_sel_oh = 16'(1) << i_addr_sel; m_busy = 1;
        end else begin
          error_resp(i_addr_sel);
        end
      end
    end else begin
      m_age++;
      if (!i_wb_cyc) begin
        m_wait = 0; m_sel_oh = '0; m_busy = 0;
      end else if (i_ack[m_wsel]) begin
        m_wait = 0; m_resp = 1; m_ack = 1; m_busy = 1; m_sel_oh = '0;
        m_rdata = i_rdata[9'(int'(m_wsel) * DW) +: DW];
      end else if (m_age == TMO) begin
        m_wait = 0;
        error_resp(m_wsel);
      end
    end
  endtask

  task automatic compare_all();
    logic [70:0] act, exp;
    act = {o_slave_sel, o_rdata, o_ack, o_err, o_busy, o_err_count, o_err_sel};
    exp = {m_sel_oh, m_rdata, m_ack, m_err, m_busy, 16'(m_cnt), m_esel};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got sel=%h rd=%h ack=%b err=%b busy=%b cnt=%h esel=%h expected sel=%h rd=%h ack=%b err=%b busy=%b cnt=%h esel=%h",
               $time, o_slave_sel, o_rdata, o_ack, o_err, o_busy, o_err_count, o_err_sel,
               m_sel_oh, m_rdata, m_ack, m_err, m_busy, 16'(m_cnt), m_esel);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic go_idle();
    i_reset = 0; i_wb_cyc = 0; i_wb_stb = 0; i_ack = '0;
  endtask

  task automatic drive_random();
    i_reset    = ($urandom_range(0, 299) == 0);
    i_wb_cyc   = ($urandom_range(0, 15) != 0);
    i_wb_stb   = 1'($urandom_range(0, 1));
    i_addr_sel = 4'($urandom_range(0, 15));
    i_ack      = 16'($urandom) & 16'($urandom);
    for (int s = 0; s < NS; s++) i_rdata[9'(s * DW) +: DW] = $urandom;
  endtask

  initial begin
    @(negedge clk);

    // Reset state
    i_reset = 1;
    tick();
    chk("rst_slave_sel", 32'(o_slave_sel), 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_ack_err_busy", 32'({o_ack, o_err, o_busy}), 32'h0);
    chk("rst_err_count", 32'(o_err_count), 32'h0);
    chk("rst_err_sel", 32'(o_err_sel), 32'h0);
    go_idle();
    tick();

    // Mapped read on slave 0
    i_wb_cyc = 1; i_wb_stb = 1; i_addr_sel = 4'd0;
    tick();
    chk("map_slave_sel", 32'(o_slave_sel), 32'h0001);
    chk("map_busy", 32'(o_busy), 32'h1);
    i_wb_stb = 0; i_ack = 16'h0001; i_rdata[31:0] = 32'h1234_5678;
    tick();
    chk("map_ack", 32'({o_ack, o_err}), 32'h2);
    chk("map_rdata", o_rdata, 32'h1234_5678);
    chk("map_sel_drop", 32'(o_slave_sel), 32'h0);
    go_idle();
    tick();
    chk("map_ack_one_cycle", 32'(o_ack), 32'h0);
    chk("map_err_count", 32'(o_err_count), 32'h0);

    // Unmapped slave 4
    i_wb_cyc = 1; i_wb_stb = 1; i_addr_sel = 4'd4;
    tick();
    chk("unmap_err", 32'({o_ack, o_err}), 32'h1);
    chk("unmap_rdata", o_rdata, 32'hDEAD_BEEF);
    chk("unmap_slave_sel", 32'(o_slave_sel), 32'h0);
    chk("unmap_err_count", 32'(o_err_count), 32'h1);
    chk("unmap_err_sel", 32'(o_err_sel), 32'h4);
    go_idle();
    tick();

    // Timeout on slave 1 with a spurious ack from slave 3 throughout
    i_wb_cyc = 1; i_wb_stb = 1; i_addr_sel = 4'd1; i_ack = 16'h0008;
    tick();
    i_wb_stb = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n < 8) begin
        chk("tmo_early_err", 32'({o_ack, o_err}), 32'h0);
        chk("tmo_slave_sel", 32'(o_slave_sel), 32'h0002);
      end
    end
    chk("tmo_err", 32'({o_ack, o_err}), 32'h1);
    chk("tmo_slave_sel_drop", 32'(o_slave_sel), 32'h0);
    chk("tmo_err_sel", 32'(o_err_sel), 32'h1);
    chk("tmo_err_count", 32'(o_err_count), 32'h2);
    go_idle();
    tick();

    // Ack in the final timeout cycle wins
    i_wb_cyc = 1; i_wb_stb = 1; i_addr_sel = 4'd2;
    tick();
    i_wb_stb = 0;
    repeat (7) tick();
    i_ack = 16'h0004; i_rdata[95:64] = 32'hCAFE_0002;
    tick();
    chk("late_ack", 32'({o_ack, o_err}), 32'h2);
    chk("late_rdata", o_rdata, 32'hCAFE_0002);
    chk("late_err_count", 32'(o_err_count), 32'h2);
    go_idle();
    tick();

    // cyc drop together with ack aborts silently
    i_wb_cyc = 1; i_wb_stb = 1; i_addr_sel = 4'd0;
    tick();
    i_wb_cyc = 0; i_wb_stb = 0; i_ack = 16'h0001;
    tick();
    chk("abort_resp", 32'({o_ack, o_err, o_busy}), 32'h0);
    chk("abort_slave_sel", 32'(o_slave_sel), 32'h0);
    go_idle();
    tick();

    // Reset mid-ACTIVE
    i_wb_cyc = 1; i_wb_stb = 1; i_addr_sel = 4'd8;
    tick();
    i_wb_stb = 0;
    tick();
    chk("rstmid_slave_sel", 32'(o_slave_sel), 32'h0100);
    i_reset = 1;
    tick();
    chk("rstmid_resp", 32'({o_ack, o_err, o_busy}), 32'h0);
    chk("rstmid_slave_sel_drop", 32'(o_slave_sel), 32'h0);
    chk("rstmid_err_count", 32'(o_err_count), 32'h0);
    go_idle();
    tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      tick();
    end

    // Error counter saturation: back-to-back unmapped requests, one error per 2 cycles
    i_reset = 1;
    tick();
    go_idle();
    i_wb_cyc = 1; i_wb_stb = 1; i_addr_sel = 4'd4;
    for (int c = 0; c < 2 * 65540; c++) tick();
    chk("sat_err_count", 32'(o_err_count), 32'h0000_FFFF);
    chk("sat_err_sel", 32'(o_err_sel), 32'h4);
    go_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
